rank_solver_ctrl: RTL and testbench

//  Sequencing controller for the 3x3 linear-system datapath `rank`.
//  - Accepts one packed system (coefficients + RHS) per valid/ready handshake and registers it onto the `rank` inputs.
//  - Waits a fixed settle time, then captures determinant y and classifications y1/y2/y3.
//  - Presents the captured result on a valid/ready output port.
//  - Sits between the system-level job source and the combinational solver.

---
 rtl/rank_ctrl_pkg.sv | 50 +++++
 rtl/rank.sv | 44 ++++
 rtl/rank_solver_ctrl.sv | 101 ++++++++++
 tb/tb_rank_solver_ctrl.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rank_ctrl_pkg.sv
// Shared types, defaults and helpers for the rank solver controller.
// Coefficients are signed CW-bit values packed a1-first into in_sys.
package rank_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW_DEF   = 3;
    localparam int DW_DEF   = 9;
    localparam int N_FIELDS = 12;

    localparam int F_A1 = 0;
    localparam int F_B1 = 1;
    localparam int F_C1 = 2;
    localparam int F_D1 = 3;
    localparam int F_A2 = 4;
    localparam int F_B2 = 5;
    localparam int F_C2 = 6;
    localparam int F_D2 = 7;
    localparam int F_A3 = 8;
    localparam int F_B3 = 9;
    localparam int F_C3 = 10;
    localparam int F_D3 = 11;

    // Field 0 (a1) sits in the most significant slot.
    function automatic int fld_lsb(input int idx, input int cw);
        return (N_FIELDS - 1 - idx) * cw;
    endfunction

    function automatic int det3(
        input int a1, input int b1, input int c1,
        input int a2, input int b2, input int c2,
        input int a3, input int b3, input int c3
    );
        return a1 * (b2 * c3 - b3 * c2)
             - b1 * (a2 * c3 - a3 * c2)
             + c1 * (a2 * b3 - a3 * b2);
    endfunction

    // 00 zero, 01 positive, 10 negative
    function automatic logic [1:0] cls2(input int v);
        if (v == 0) return 2'b00;
        if (v > 0) return 2'b01;
        return 2'b10;
    endfunction

endpackage

// File: rtl/rank.sv
// Combinational 3x3 solver: determinant y and sign class of each
// Cramer numerator (y1 for x, y2 for y, y3 for z).
module rank
    import rank_ctrl_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic [N_FIELDS*CW-1:0] sys,
    output logic [DW-1:0]          y,
    output logic [1:0]             y1,
    output logic [1:0]             y2,
    output logic [1:0]             y3
);

    int f [N_FIELDS];
    int dt;
    int dx;
    int dy;
    int dz;

    for (genvar i = 0; i < N_FIELDS; i++) begin : g_unpack
        assign f[i] = int'($signed(sys[fld_lsb(i, CW) +: CW]));
    end

    assign dt = det3(f[F_A1], f[F_B1], f[F_C1],
                     f[F_A2], f[F_B2], f[F_C2],
                     f[F_A3], f[F_B3], f[F_C3]);
    assign dx = det3(f[F_D1], f[F_B1], f[F_C1],
                     f[F_D2], f[F_B2], f[F_C2],
                     f[F_D3], f[F_B3], f[F_C3]);
    assign dy = det3(f[F_A1], f[F_D1], f[F_C1],
                     f[F_A2], f[F_D2], f[F_C2],
                     f[F_A3], f[F_D3], f[F_C3]);
    assign dz = det3(f[F_A1], f[F_B1], f[F_D1],
                     f[F_A2], f[F_B2], f[F_D2],
                     f[F_A3], f[F_B3], f[F_D3]);

    assign y  = DW'(dt);
    assign y1 = cls2(dx);
    assign y2 = cls2(dy);
    assign y3 = cls2(dz);

endmodule

// File: rtl/rank_solver_ctrl.sv
// Sequencer around the rank datapath: accept a system, let it settle
// for EVAL_CYCLES, capture the result and offer it downstream.
module rank_solver_ctrl
    import rank_ctrl_pkg::*;
#(
    parameter int CW          = CW_DEF,
    parameter int DW          = DW_DEF,
    parameter int EVAL_CYCLES = 2,
    parameter int TAG_W       = 4,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_FIELDS*CW-1:0] in_sys,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW-1:0]          out_det,
    output logic [5:0]             out_cls,
    output logic                   out_singular,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   busy,
    output logic [CNT_W-1:0]       job_count
);

    localparam int CTR_W = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;
    localparam logic [CTR_W-1:0] CNT_LOAD = CTR_W'(EVAL_CYCLES - 1);

    state_t                  state;
    logic [CTR_W-1:0]        cnt;
    logic [N_FIELDS*CW-1:0]  sys_q;
    logic [TAG_W-1:0]        tag_q;
    logic [DW-1:0]           y;
    logic [1:0]              y1;
    logic [1:0]              y2;
    logic [1:0]              y3;

    rank #(
        .CW (CW),
        .DW (DW)
    ) u_rank (
        .sys (sys_q),
        .y   (y),
        .y1  (y1),
        .y2  (y2),
        .y3  (y3)
    );

    // Handshake flags depend on state only, never on in_valid/out_ready.
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            sys_q        <= '0;
            tag_q        <= '0;
            out_valid    <= 1'b0;
            out_det      <= '0;
            out_cls      <= '0;
            out_singular <= 1'b0;
            out_tag      <= '0;
            job_count    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        sys_q <= in_sys;
                        tag_q <= in_tag;
                        cnt   <= CNT_LOAD;
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    if (cnt == '0) begin
                        out_det      <= y;
                        out_cls      <= {y1, y2, y3};
                        out_singular <= (y == '0);
                        out_tag      <= tag_q;
                        out_valid    <= 1'b1;
                        state        <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        job_count <= job_count + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rank_solver_ctrl.sv
// Directed bench for rank_solver_ctrl with a Sarrus-rule reference.
// A second instance with CNT_W=2 exercises job_count wrap.
module tb_rank_solver_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst2 = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [35:0] in_sys = '0;
    logic [3:0]  in_tag = '0;

    logic        in_ready;
    logic        out_valid;
    logic [8:0]  out_det;
    logic [5:0]  out_cls;
    logic        out_singular;
    logic [3:0]  out_tag;
    logic        busy;
    logic [7:0]  job_count;

    logic        in_ready2;
    logic        out_valid2;
    logic [8:0]  out_det2;
    logic [5:0]  out_cls2;
    logic        out_singular2;
    logic [3:0]  out_tag2;
    logic        busy2;
    logic [1:0]  job_count2;

    int checks = 0;
    int errors = 0;
    int exp_jc = 0;

    always #5 clk = ~clk;

    rank_solver_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sys       (in_sys),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_det      (out_det),
        .out_cls      (out_cls),
        .out_singular (out_singular),
        .out_tag      (out_tag),
        .busy         (busy),
        .job_count    (job_count)
    );

    rank_solver_ctrl #(.CNT_W(2)) dut2 (
        .clk          (clk),
        .rst          (rst2),
        .in_valid     (in_valid),
        .in_ready     (in_ready2),
        .in_sys       (in_sys),
        .in_tag       (in_tag),
        .out_valid    (out_valid2),
        .out_ready    (out_ready),
        .out_det      (out_det2),
        .out_cls      (out_cls2),
        .out_singular (out_singular2),
        .out_tag      (out_tag2),
        .busy         (busy2),
        .job_count    (job_count2)
    );

    function automatic logic [35:0] pack(
        input int a1, input int b1, input int c1, input int d1,
        input int a2, input int b2, input int c2, input int d2,
        input int a3, input int b3, input int c3, input int d3
    );
        return {3'(a1), 3'(b1), 3'(c1), 3'(d1),
                3'(a2), 3'(b2), 3'(c2), 3'(d2),
                3'(a3), 3'(b3), 3'(c3), 3'(d3)};
    endfunction

    function automatic int fv(input logic [35:0] s, input int i);
        logic signed [2:0] v;
        v = s[(11 - i) * 3 +: 3];
        return int'(v);
    endfunction

    function automatic int sarrus(
        input int p, input int q, input int r,
        input int s, input int t, input int u,
        input int v, input int w, input int x
    );
        return p * t * x + q * u * v + r * s * w
             - r * t * v - p * u * w - q * s * x;
    endfunction

    function automatic logic [1:0] sg(input int v);
        if (v == 0) return 2'b00;
        return (v > 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [8:0] m_det(input logic [35:0] s);
        return 9'(sarrus(fv(s, 0), fv(s, 1), fv(s, 2),
                         fv(s, 4), fv(s, 5), fv(s, 6),
                         fv(s, 8), fv(s, 9), fv(s, 10)));
    endfunction

    function automatic logic [5:0] m_cls(input logic [35:0] s);
        int dx;
        int dy;
        int dz;
        dx = sarrus(fv(s, 3), fv(s, 1), fv(s, 2),
                    fv(s, 7), fv(s, 5), fv(s, 6),
                    fv(s, 11), fv(s, 9), fv(s, 10));
        dy = sarrus(fv(s, 0), fv(s, 3), fv(s, 2),
                    fv(s, 4), fv(s, 7), fv(s, 6),
                    fv(s, 8), fv(s, 11), fv(s, 10));
        dz = sarrus(fv(s, 0), fv(s, 1), fv(s, 3),
                    fv(s, 4), fv(s, 5), fv(s, 7),
                    fv(s, 8), fv(s, 9), fv(s, 11));
        return {sg(dx), sg(dy), sg(dz)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [35:0] s, input logic [3:0] t);
        in_sys   = s;
        in_tag   = t;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_ready got=%b exp=1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_flags got=%b%b exp=00", out_valid, busy);
        end
        checks++;
        if (out_det !== 9'd0 || out_cls !== 6'd0 || out_singular !== 1'b0) begin
            errors++;
            $display("FAIL rst_data got=%h/%b/%b exp=0/0/0",
                     out_det, out_cls, out_singular);
        end
        checks++;
        if (out_tag !== 4'd0 || job_count !== 8'd0) begin
            errors++;
            $display("FAIL rst_tag_cnt got=%h/%0d exp=0/0", out_tag, job_count);
        end
    endtask

    task automatic test_identity();
        out_ready = 1'b1;
        accept(pack(1, 0, 0, 1, 0, 1, 0, 2, 0, 0, 1, 3), 4'hA);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL id_accept got=%b%b%b exp=100", busy, in_ready, out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL id_early got=%b exp=0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL id_valid got=%b exp=1", out_valid);
        end
        checks++;
        if (out_det !== 9'd1 || out_singular !== 1'b0) begin
            errors++;
            $display("FAIL id_det got=%h/%b exp=1/0", out_det, out_singular);
        end
        checks++;
        if (out_cls !== 6'b010101 || out_tag !== 4'hA) begin
            errors++;
            $display("FAIL id_cls_tag got=%b/%h exp=010101/a", out_cls, out_tag);
        end
        tick();
        exp_jc++;
        checks++;
        if (out_valid !== 1'b0 || job_count !== 8'(exp_jc) || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL id_hs got=%b/%0d/%b exp=0/%0d/1",
                     out_valid, job_count, in_ready, exp_jc);
        end
        checks++;
        if (out_det !== 9'd1) begin
            errors++;
            $display("FAIL id_retain got=%h exp=1", out_det);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL id_single got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_zero();
        int n;
        out_ready = 1'b1;
        accept('0, 4'h3);
        wait_out(n);
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL zero_latency got=%0d exp=2", n);
        end
        checks++;
        if (out_det !== 9'd0 || out_singular !== 1'b1 || out_cls !== 6'd0) begin
            errors++;
            $display("FAIL zero_data got=%h/%b/%b exp=0/1/0",
                     out_det, out_singular, out_cls);
        end
        tick();
        exp_jc++;
        checks++;
        if (job_count !== 8'(exp_jc)) begin
            errors++;
            $display("FAIL zero_cnt got=%0d exp=%0d", job_count, exp_jc);
        end
    endtask

    task automatic test_back_pressure();
        int n;
        out_ready = 1'b0;
        accept(pack(2, 1, 0, 1, 1, 3, 0, -1, 0, 0, 1, 2), 4'h5);
        wait_out(n);
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL bp_timeout got=%0d exp=<20", n);
        end
        in_sys   = pack(-1, 0, 0, 1, 0, 1, 0, 2, 0, 0, 1, 3);
        in_tag   = 4'h6;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d] got=%b%b exp=10", i, out_valid, in_ready);
            end
            checks++;
            if (out_det !== 9'd5 || out_cls !== 6'b011001 || out_tag !== 4'h5) begin
                errors++;
                $display("FAIL bp_data[%0d] got=%h/%b/%h exp=5/011001/5",
                         i, out_det, out_cls, out_tag);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        exp_jc++;
        checks++;
        if (out_valid !== 1'b0 || job_count !== 8'(exp_jc) || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got=%b/%0d/%b exp=0/%0d/1",
                     out_valid, job_count, in_ready, exp_jc);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_tag !== 4'h5) begin
            errors++;
            $display("FAIL b2b_accept got=%b/%h exp=1/5", busy, out_tag);
        end
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_det !== 9'h1FF) begin
            errors++;
            $display("FAIL b2b_det got=%b/%h exp=1/1ff", out_valid, out_det);
        end
        checks++;
        if (out_cls !== 6'b011010 || out_tag !== 4'h6 || out_singular !== 1'b0) begin
            errors++;
            $display("FAIL b2b_cls got=%b/%h/%b exp=011010/6/0",
                     out_cls, out_tag, out_singular);
        end
        tick();
        exp_jc++;
        out_ready = 1'b0;
        checks++;
        if (job_count !== 8'(exp_jc)) begin
            errors++;
            $display("FAIL b2b_cnt got=%0d exp=%0d", job_count, exp_jc);
        end
    endtask

    task automatic test_random();
        int n;
        logic [63:0] r;
        logic [35:0] s;
        for (int j = 0; j < 20; j++) begin
            repeat ($urandom_range(0, 3)) tick();
            r = {$urandom(), $urandom()};
            s = r[35:0];
            accept(s, 4'(j));
            wait_out(n);
            checks++;
            if (n >= 20) begin
                errors++;
                $display("FAIL rnd_timeout[%0d] got=%0d exp=<20", j, n);
            end
            checks++;
            if (out_det !== m_det(s) || out_singular !== (m_det(s) == 9'd0)) begin
                errors++;
                $display("FAIL rnd_det[%0d] got=%h/%b exp=%h", j, out_det,
                         out_singular, m_det(s));
            end
            checks++;
            if (out_cls !== m_cls(s)) begin
                errors++;
                $display("FAIL rnd_cls[%0d] got=%b exp=%b", j, out_cls, m_cls(s));
            end
            checks++;
            if (out_tag !== 4'(j)) begin
                errors++;
                $display("FAIL rnd_tag[%0d] got=%h exp=%h", j, out_tag, 4'(j));
            end
            repeat ($urandom_range(0, 3)) tick();
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            exp_jc++;
            checks++;
            if (out_valid !== 1'b0 || job_count !== 8'(exp_jc)) begin
                errors++;
                $display("FAIL rnd_hs[%0d] got=%b/%0d exp=0/%0d",
                         j, out_valid, job_count, exp_jc);
            end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        accept(pack(1, 0, 0, 1, 0, 1, 0, 2, 0, 0, 1, 3), 4'h7);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_jc = 0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst got=%b%b%b exp=100", in_ready, out_valid, busy);
        end
        checks++;
        if (job_count !== 8'd0 || out_det !== 9'd0) begin
            errors++;
            $display("FAIL mid_rst_regs got=%0d/%h exp=0/0", job_count, out_det);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_no_pulse[%0d] got=%b exp=0", i, out_valid);
            end
        end
    endtask

    task automatic test_wrap();
        int n;
        int seq [5] = '{1, 2, 3, 0, 1};
        rst2 = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (job_count2 !== 2'd0) begin
            errors++;
            $display("FAIL wrap_init got=%0d exp=0", job_count2);
        end
        for (int k = 0; k < 5; k++) begin
            accept(pack(k, 1, 0, 1, 0, 1, 0, 2, 0, 0, 1, 3), 4'(k));
            wait_out(n);
            tick();
            exp_jc++;
            checks++;
            if (job_count2 !== 2'(seq[k]) || out_valid2 !== 1'b0) begin
                errors++;
                $display("FAIL wrap_cnt[%0d] got=%0d/%b exp=%0d/0",
                         k, job_count2, out_valid2, seq[k]);
            end
            checks++;
            if (job_count !== 8'(exp_jc)) begin
                errors++;
                $display("FAIL wrap_main[%0d] got=%0d exp=%0d", k, job_count, exp_jc);
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_zero();
        test_back_pressure();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
